// File: rtl/pc_pkg.sv
// Shared constants for the program-counter generator: mode encodings and reset PC.
package pc_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned IMM26_W = 26;

  localparam logic [MODE_W-1:0] PC_SEQ  = 3'd0;
  localparam logic [MODE_W-1:0] PC_BEQ  = 3'd1;
  localparam logic [MODE_W-1:0] PC_BNE  = 3'd2;
  localparam logic [MODE_W-1:0] PC_J    = 3'd3;
  localparam logic [MODE_W-1:0] PC_JAL  = 3'd4;
  localparam logic [MODE_W-1:0] PC_JR   = 3'd5;
  localparam logic [MODE_W-1:0] PC_JRRA = 3'd6;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pc_gen_if.sv
// Controller <-> PC generator bundle; master is the controller side.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  import pc_pkg::*;

  logic                 stall;
  logic [MODE_W-1:0]    mode;
  logic                 zero;
  logic [WIDTH-1:0]     ext_imm;
  logic [IMM26_W-1:0]   imm26;
  logic [WIDTH-1:0]     reg_target;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc4;
  logic [WIDTH-1:0]     npc;
  logic                 ras_empty;
  logic                 ras_err;
  logic                 misalign;

  modport master (
    output stall, mode, zero, ext_imm, imm26, reg_target,
    input  pc, pc4, npc, ras_empty, ras_err, misalign
  );

  modport slave (
    input  stall, mode, zero, ext_imm, imm26, reg_target,
    output pc, pc4, npc, ras_empty, ras_err, misalign
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top_c,
  output logic             empty_c,
  output logic             err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q;
  logic             full;

  // ptr_q points at the next free slot, so the top lives one below it
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_c   = mem_q[top_idx];
  assign empty_c = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Entry storage: pushes always write at ptr, wrapping over the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= din;
    end
  end

  // Pointer, occupancy and sticky overflow/underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err   <= 1'b0;
    end else if (push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (full) err   <= 1'b1;
      else      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop) begin
      if (empty_c) begin
        err <= 1'b1;
      end else begin
        ptr_q <= ptr_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// PC register, next-PC mux and return-address stack control.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_PC  = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_gen_if.slave   bus
);

  localparam logic [WIDTH-1:0] JMP_LOW_MASK = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc4_c;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty_c;
  logic             ras_err_q;
  logic             ras_push;
  logic             ras_pop;

  assign pc4_c   = pc_q + WIDTH'(4);
  assign br_off  = bus.ext_imm << 2;
  assign br_tgt  = pc4_c + br_off;
  assign jmp_tgt = (pc4_c & ~JMP_LOW_MASK) | WIDTH'({bus.imm26, 2'b00});

  // Next-PC select; unlisted modes fall through to sequential
  always_comb begin
    raw_tgt       = pc4_c;
    bus.misalign  = 1'b0;
    case (bus.mode)
      PC_BEQ:  raw_tgt = bus.zero  ? br_tgt : pc4_c;
      PC_BNE:  raw_tgt = !bus.zero ? br_tgt : pc4_c;
      PC_J,
      PC_JAL:  raw_tgt = jmp_tgt;
      PC_JR:   raw_tgt = bus.reg_target;
      PC_JRRA: raw_tgt = ras_empty_c ? bus.reg_target : ras_top;
      default: raw_tgt = pc4_c;
    endcase
    if ((bus.mode == PC_JR) || (bus.mode == PC_JRRA))
      bus.misalign = (raw_tgt[1:0] != 2'b00);
  end

  assign bus.npc       = {raw_tgt[WIDTH-1:2], 2'b00};
  assign bus.pc4       = pc4_c;
  assign bus.pc        = pc_q;
  assign bus.ras_empty = ras_empty_c;
  assign bus.ras_err   = ras_err_q;

  // Stack ops only happen on cycles where the PC actually advances
  assign ras_push = !bus.stall && (bus.mode == PC_JAL);
  assign ras_pop  = !bus.stall && (bus.mode == PC_JRRA);

  // PC register: holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc_q <= RESET_PC;
    else if (!bus.stall) pc_q <= bus.npc;
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .din     (pc4_c),
    .top_c   (ras_top),
    .empty_c (ras_empty_c),
    .err     (ras_err_q)
  );

endmodule
